cgia_shifter: RTL and testbench
===============================

Name: cgia_shifter

Overview:
- Downstream consumer of the CGIA fetcher.
- Double-buffers the 16-bit words the fetcher deposits via its line-buffer write strobe, then serializes the previous line's words into a 1-bpp pixel stream during active display.
- Sits between the fetcher (write side) and the video DAC/output stage (read side), and is timed by CRTC HSYNC/VSYNC/HDE and the REGSET DEN and line length.

Parameters:
- WORD_W, 16, width of a fetched word and of the shift register.
- ADR_W, 9, line-buffer address width; must match the width of line_len_i.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- hsync_i  in  1  CRTC HSYNC, active high; rising edge marks a line boundary.
- vsync_i  in  1  CRTC VSYNC, active high.
- hde_i  in  1  CRTC horizontal display enable (active video window).
- den_i  in  1  REGSET display enable.
- line_len_i  in  ADR_W  words per line; same value fed to the fetcher.
- s_we_i  in  1  line-buffer write strobe from the fetcher.
- s_dat_i  in  WORD_W  data accompanying s_we_i (the word acked on the bus).
- pixel_o  out  1  serialized pixel, MSB of each word first.
- pixel_en_o  out  1  high while pixel_o carries buffer data.
- underrun_o  out  1  one-cycle pulse when the display needs a word that was never written.

Behaviour:

Reset (reset_i low, asynchronous):
- wr_bank=0, wr_ptr=0.
- wr_cnt[0]=wr_cnt[1]=0.
- rd_ptr=0, shift register=0, bit counter=0.
- pixel_o=0, pixel_en_o=0, underrun_o=0.
- Buffer RAM contents are not reset.

Edge detection:
- hsync_i and hde_i are registered once.
- A rise is current=1 and previous=0.

Line swap (hsync rise):
- wr_bank toggles; rd_bank is always the complement of wr_bank.
- wr_ptr is set to 0, and wr_cnt of the new wr_bank is set to 0.
- Words fetched during line N are displayed on line N+1.

Write side:
- When s_we_i=1 and wr_ptr < line_len_i: store s_dat_i at bank[wr_bank][wr_ptr], then increment wr_ptr and wr_cnt[wr_bank].
- When wr_ptr >= line_len_i: the write is dropped and the pointer holds.
- Writes are accepted regardless of den_i or hde_i.
- Simultaneous hsync rise and s_we_i: the swap takes effect first; the word goes to address 0 of the new wr_bank, after which wr_ptr=1 and wr_cnt=1.

VSYNC:
- While vsync_i=1, both wr_cnt are held at 0.
- The first line after VSYNC therefore displays blank and raises no underrun.

Read side states (IDLE, PRIME, SHIFT, BORDER):
- IDLE:
  - pixel_o=0, pixel_en_o=0.
  - On hde rise with den_i=1: issue a read of rd_bank address 0, set rd_ptr=1, go to PRIME.
  - If line_len_i=0 or wr_cnt[rd_bank]=0: go to BORDER instead (no underrun when wr_cnt=0 because of VSYNC).
- PRIME (1 cycle, registered RAM latency):
  - Load the shift register with RAM data and set bit counter=15.
  - Issue a prefetch read at rd_ptr; go to SHIFT.
- SHIFT:
  - Each clock: pixel_o = shift[15], pixel_en_o=1, shift left by 1, decrement bit counter.
  - At bit counter=0:
    - If rd_ptr < line_len_i: reload from the prefetched word, increment rd_ptr, issue the next prefetch. This gives seamless 16 pixels per word with no gap.
    - Otherwise go to BORDER.
  - If the word reloaded has index >= wr_cnt[rd_bank]: pulse underrun_o for 1 cycle, go to BORDER.
- BORDER:
  - pixel_o=0, pixel_en_o=0 until hde falls, then go to IDLE.

Abort conditions:
- hde_i falling in any state forces IDLE on the next clock.
- den_i=0 in any state forces IDLE; pixel_o is 0 from the same clock.

Latency:
- The first pixel appears on pixel_o 3 clocks after hde_i goes high: 1 cycle edge register, 1 cycle PRIME, 1 cycle output register.

Arithmetic:
- wr_ptr, rd_ptr and wr_cnt are ADR_W bits and unsigned.
- Comparisons are unsigned; a line_len_i of 511 is fully usable, and the pointers never wrap.

Decomposition:
- Shared package cgia_pkg:
  - WORD_W and ADR_W constants.
  - Read-state enum: IDLE, PRIME, SHIFT, BORDER.
- Sub-module cgia_linebuf_ram:
  - 2 x 2^ADR_W x WORD_W simple dual-port RAM, with 1 write port and 1 registered read port.
  - Bank select is the MSB of the address; infers block RAM.
- Top-level logic in cgia_shifter: swap/pointers, FSM, shift register.

Test Plan:
- Reset: drive reset_i low mid-SHIFT -> pixel_o, pixel_en_o and underrun_o go 0 immediately (asynchronous); after release, the block is in IDLE.
- Basic line, line_len_i=2:
  - Stimulus: hsync rise, write 16'hA5F0 then 16'h8001; next hsync rise; hde high with den=1.
  - Required: from 3 clocks after hde, pixel_o = 1010010111110000 1000000000000001 with pixel_en_o=1 for exactly 32 clocks, then 0.
- Double buffering: while line 1 displays, write line 2 with 16'hFFFF x2 -> line 1 pixels are unchanged; after the next hsync, 32 ones are shown.
- Overflow and collision:
  - line_len_i=2: write 3 words -> the third is dropped and not displayed.
  - s_we_i in the same cycle as the hsync rise -> the word is displayed first on the following line.
- Underrun: line_len_i=3 but only 2 words written -> underrun_o pulses once at the 33rd pixel slot; pixel_o=0 afterwards.
- VSYNC / DEN:
  - With vsync_i high during a line's writes -> the next line is blank with no underrun.
  - den_i=0 mid-line -> pixel_o=0 from the same clock.

Source files
------------

// File: rtl/cgia_pkg.sv
// Shared constants and types for the CGIA line shifter.
//   WORD_W     : width of a fetched word / shift register
//   ADR_W      : line-buffer address width (one bank)
//   rd_state_t : read-side (display) state machine encoding
package cgia_pkg;

   localparam int WORD_W = 16;
   localparam int ADR_W  = 9;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      SHIFT  = 2'd2,
      BORDER = 2'd3
   } rd_state_t;

endpackage

// File: rtl/cgia_linebuf_ram.sv
// Two-bank line buffer: simple dual-port RAM, one write port and one
// registered read port. The address MSB selects the bank. No reset on the
// array or the read register so that it maps onto block RAM.
//   i_clk    : clock
//   i_we     : write enable
//   i_waddr  : {bank, word index} write address
//   i_wdata  : write data
//   i_re     : read enable; o_rdata holds its value while low
//   i_raddr  : {bank, word index} read address
//   o_rdata  : registered read data (one cycle latency)
module cgia_linebuf_ram
   import cgia_pkg::*;
#(
   parameter int WORD_W = cgia_pkg::WORD_W,
   parameter int ADR_W  = cgia_pkg::ADR_W
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADR_W:0]    i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic              i_re,
   input  logic [ADR_W:0]    i_raddr,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [2**(ADR_W+1)];
   logic [WORD_W-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/cgia_shifter.sv
// CGIA shifter: double-buffers the words deposited by the fetcher and
// serializes the previous line's words into a 1-bpp pixel stream.
//   clk_i       : system clock
//   reset_i     : asynchronous active-low reset
//   hsync_i     : CRTC HSYNC; rising edge swaps the line banks
//   vsync_i     : CRTC VSYNC; holds both bank word counts at zero
//   hde_i       : CRTC horizontal display enable
//   den_i       : display enable; low aborts display and blanks output
//   line_len_i  : words per line
//   s_we_i      : line-buffer write strobe from the fetcher
//   s_dat_i     : word accompanying s_we_i
//   pixel_o     : serialized pixel, word MSB first
//   pixel_en_o  : high while pixel_o carries buffer data
//   underrun_o  : one-cycle pulse when a never-written word is needed
//
// Read-side states:
//   state  | meaning
//   IDLE   | waiting for an hde rise with den high, output blank
//   PRIME  | first word in flight from the registered RAM port
//   SHIFT  | shifting pixels out, reloading from the prefetched word
//   BORDER | line finished or unavailable, blank until hde falls
module cgia_shifter
   import cgia_pkg::*;
#(
   parameter int WORD_W = cgia_pkg::WORD_W,
   parameter int ADR_W  = cgia_pkg::ADR_W
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              hsync_i,
   input  logic              vsync_i,
   input  logic              hde_i,
   input  logic              den_i,
   input  logic [ADR_W-1:0]  line_len_i,
   input  logic              s_we_i,
   input  logic [WORD_W-1:0] s_dat_i,
   output logic              pixel_o,
   output logic              pixel_en_o,
   output logic              underrun_o
);

   localparam int BIT_W = $clog2(WORD_W);

   logic                       r_hsync_q;
   logic                       r_hde_q;
   logic                       w_hsync_rise;
   logic                       w_hde_rise;
   logic                       w_hde_fall;

   logic                       r_wr_bank;
   logic [ADR_W-1:0]           r_wr_ptr;
   logic [1:0][ADR_W-1:0]      r_wr_cnt;
   logic                       w_wr_bank;
   logic [ADR_W-1:0]           w_wr_ptr;
   logic [ADR_W-1:0]           w_wr_cnt;
   logic                       w_wr_en;

   rd_state_t                  r_state;
   rd_state_t                  w_state_nxt;
   logic                       w_rd_bank;
   logic [ADR_W-1:0]           w_rd_cnt;
   logic [ADR_W-1:0]           w_rd_idx;
   logic                       w_rd_en;
   logic [WORD_W-1:0]          w_rd_data;
   logic [ADR_W-1:0]           r_rd_ptr;
   logic [WORD_W-1:0]          r_shift;
   logic [BIT_W-1:0]           r_bit_cnt;
   logic                       r_pixel;
   logic                       r_pixel_en;
   logic                       r_urun_arm;
   logic                       r_underrun;

   logic                       w_start;
   logic                       w_load;
   logic                       w_shift;
   logic                       w_reload;
   logic                       w_urun;

   // Edge detection against the once-registered copies
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_hsync_q <= 1'b0;
         r_hde_q   <= 1'b0;
      end else begin
         r_hsync_q <= hsync_i;
         r_hde_q   <= hde_i;
      end
   end

   assign w_hsync_rise = hsync_i & ~r_hsync_q;
   assign w_hde_rise   = hde_i & ~r_hde_q;
   assign w_hde_fall   = ~hde_i & r_hde_q;

   // Write side: a swap in the same cycle as a write applies first, so the
   // word lands at index 0 of the new bank.
   assign w_wr_bank = w_hsync_rise ? ~r_wr_bank : r_wr_bank;
   assign w_wr_ptr  = w_hsync_rise ? '0 : r_wr_ptr;
   assign w_wr_cnt  = w_hsync_rise ? '0 : r_wr_cnt[w_wr_bank];
   assign w_wr_en   = s_we_i && (w_wr_ptr < line_len_i);

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_wr_bank <= 1'b0;
         r_wr_ptr  <= '0;
         r_wr_cnt  <= '0;
      end else begin
         r_wr_bank           <= w_wr_bank;
         r_wr_ptr            <= w_wr_en ? w_wr_ptr + 1'b1 : w_wr_ptr;
         r_wr_cnt[w_wr_bank] <= w_wr_en ? w_wr_cnt + 1'b1 : w_wr_cnt;
         if (vsync_i) r_wr_cnt <= '0;
      end
   end

   // Read side: the bank not being written
   assign w_rd_bank = ~r_wr_bank;
   assign w_rd_cnt  = r_wr_cnt[w_rd_bank];

   // RAM read register tracks rd_ptr; in IDLE it sits on word 0 so that
   // PRIME can load immediately. rd_ptr is stable for a whole word, so the
   // register always holds the next word by the time it is needed.
   assign w_rd_idx = (r_state == IDLE) ? '0 : r_rd_ptr;
   assign w_rd_en  = (r_state != BORDER);

   cgia_linebuf_ram #(
      .WORD_W (WORD_W),
      .ADR_W  (ADR_W)
   ) u_ram (
      .i_clk   (clk_i),
      .i_we    (w_wr_en),
      .i_waddr ({w_wr_bank, w_wr_ptr}),
      .i_wdata (s_dat_i),
      .i_re    (w_rd_en),
      .i_raddr ({w_rd_bank, w_rd_idx}),
      .o_rdata (w_rd_data)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_reload    = 1'b0;
      w_urun      = 1'b0;
      if (!den_i || w_hde_fall) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_hde_rise) begin
                  // Empty bank (including the post-VSYNC line) is plain border
                  if (line_len_i == '0 || w_rd_cnt == '0) begin
                     w_state_nxt = BORDER;
                  end else begin
                     w_state_nxt = PRIME;
                     w_start     = 1'b1;
                  end
               end
            end
            PRIME: begin
               w_load      = 1'b1;
               w_state_nxt = SHIFT;
            end
            SHIFT: begin
               w_shift = 1'b1;
               if (r_bit_cnt == '0) begin
                  if (r_rd_ptr >= line_len_i) begin
                     w_state_nxt = BORDER;
                  end else if (r_rd_ptr >= w_rd_cnt) begin
                     w_urun      = 1'b1;
                     w_state_nxt = BORDER;
                  end else begin
                     w_reload = 1'b1;
                  end
               end
            end
            BORDER: w_state_nxt = BORDER;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         r_rd_ptr   <= '0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_pixel    <= 1'b0;
         r_pixel_en <= 1'b0;
         r_urun_arm <= 1'b0;
         r_underrun <= 1'b0;
      end else begin
         r_pixel    <= 1'b0;
         r_pixel_en <= 1'b0;
         // Underrun is decided alongside the last good pixel; delaying it a
         // cycle places the pulse in the slot of the missing word.
         r_urun_arm <= w_urun;
         r_underrun <= r_urun_arm;
         if (w_start) r_rd_ptr <= {{(ADR_W-1){1'b0}}, 1'b1};
         if (w_load) begin
            r_shift   <= w_rd_data;
            r_bit_cnt <= BIT_W'(WORD_W - 1);
         end
         if (w_shift) begin
            r_pixel    <= r_shift[WORD_W-1];
            r_pixel_en <= 1'b1;
            if (w_reload) begin
               r_shift   <= w_rd_data;
               r_bit_cnt <= BIT_W'(WORD_W - 1);
               r_rd_ptr  <= r_rd_ptr + 1'b1;
            end else begin
               r_shift   <= {r_shift[WORD_W-2:0], 1'b0};
               r_bit_cnt <= r_bit_cnt - 1'b1;
            end
         end
      end
   end

   // den low blanks the output within the same cycle
   assign pixel_o    = r_pixel & den_i;
   assign pixel_en_o = r_pixel_en & den_i;
   assign underrun_o = r_underrun;

endmodule

// File: tb/tb_cgia_shifter.sv
// Self-checking bench for cgia_shifter. The reference model keeps each
// line's accepted words in a queue; at every hsync the current line becomes
// the displayed line, and the expected pixel stream is derived from the
// displayed queue, the line length and the 3-cycle start latency.
module tb_cgia_shifter;

   logic        clk_i      = 1'b0;
   logic        reset_i    = 1'b0;
   logic        hsync_i    = 1'b0;
   logic        vsync_i    = 1'b0;
   logic        hde_i      = 1'b0;
   logic        den_i      = 1'b1;
   logic [8:0]  line_len_i = '0;
   logic        s_we_i     = 1'b0;
   logic [15:0] s_dat_i    = '0;
   logic        pixel_o;
   logic        pixel_en_o;
   logic        underrun_o;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [15:0] q_cur[$];
   logic [15:0] q_prev[$];
   bit          cur_blank  = 1'b0;
   bit          prev_blank = 1'b0;
   int          cur_len    = 0;
   logic [15:0] wbuf[8];

   cgia_shifter #(.WORD_W(16), .ADR_W(9)) dut (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .hsync_i    (hsync_i),
      .vsync_i    (vsync_i),
      .hde_i      (hde_i),
      .den_i      (den_i),
      .line_len_i (line_len_i),
      .s_we_i     (s_we_i),
      .s_dat_i    (s_dat_i),
      .pixel_o    (pixel_o),
      .pixel_en_o (pixel_en_o),
      .underrun_o (underrun_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic swap_model();
      q_prev     = q_cur;
      prev_blank = cur_blank;
      q_cur.delete();
      cur_blank  = 1'b0;
   endtask

   task automatic write_model(input logic [15:0] d);
      if (q_cur.size() < cur_len) q_cur.push_back(d);
   endtask

   // One video line: hsync pulse (optionally colliding with the first
   // write), then the previous line is displayed while this line's words
   // are written.
   task automatic do_line(input int len, input int nw, input bit coll,
                          input bit vs, input bit show, input bit drop);
      int n;
      int v;
      int h;
      int c_d;
      bit ur;
      line_len_i = 9'(len);
      cur_len    = len;
      vsync_i    = vs;
      hsync_i    = 1'b1;
      swap_model();
      if (vs) cur_blank = 1'b1;
      if (coll && nw > 0) begin
         s_we_i  = 1'b1;
         s_dat_i = wbuf[0];
         write_model(wbuf[0]);
      end
      step();
      hsync_i = 1'b0;
      s_we_i  = 1'b0;

      v = prev_blank ? 0 : q_prev.size();
      if (len == 0 || v == 0) begin
         n = 0; ur = 1'b0;
      end else if (v >= len) begin
         n = len; ur = 1'b0;
      end else begin
         n = v; ur = 1'b1;
      end
      h   = 16 * len + 10;
      c_d = (drop && n > 0) ? int'($urandom_range(16 * n, 4)) : 0;

      fork
         begin
            for (int i = (coll && nw > 0) ? 1 : 0; i < nw; i++) begin
               int g;
               g = $urandom_range(3, 0);
               repeat (g) step();
               s_we_i  = 1'b1;
               s_dat_i = wbuf[i];
               write_model(wbuf[i]);
               step();
               s_we_i = 1'b0;
            end
         end
         begin
            if (show && !vs) begin
               hde_i = 1'b1;
               den_i = 1'b1;
               for (int c = 1; c <= h; c++) begin
                  int p;
                  bit live;
                  bit en_e;
                  bit px_e;
                  bit ur_e;
                  logic [15:0] w;
                  step();
                  p    = c - 3;
                  live = (c_d == 0) || (c <= c_d);
                  en_e = live && p >= 0 && p < 16 * n;
                  px_e = 1'b0;
                  if (en_e) begin
                     w    = q_prev[p / 16];
                     px_e = w[15 - (p % 16)];
                  end
                  ur_e = live && ur && (p == 16 * n);
                  check_val($sformatf("pixel c%0d", c), pixel_o, px_e);
                  check_val($sformatf("pixel_en c%0d", c), pixel_en_o, en_e);
                  check_val($sformatf("underrun c%0d", c), underrun_o, ur_e);
                  if (c == c_d) begin
                     den_i = 1'b0;
                     #1;
                     check_val("den drop pixel", pixel_o, 0);
                     check_val("den drop pixel_en", pixel_en_o, 0);
                  end
               end
               hde_i = 1'b0;
               step();
               check_val("after hde pixel_en", pixel_en_o, 0);
               den_i = 1'b1;
            end else begin
               repeat (h) step();
            end
         end
      join
      vsync_i = 1'b0;
      step();
   endtask

   initial begin
      // Reset state
      repeat (3) begin
         step();
         check_val("reset pixel", pixel_o, 0);
         check_val("reset pixel_en", pixel_en_o, 0);
         check_val("reset underrun", underrun_o, 0);
      end
      reset_i = 1'b1;
      repeat (2) step();

      // Basic line and double buffering
      wbuf[0] = 16'hA5F0; wbuf[1] = 16'h8001;
      do_line(2, 2, 0, 0, 1, 0);
      wbuf[0] = 16'hFFFF; wbuf[1] = 16'hFFFF;
      do_line(2, 2, 0, 0, 1, 0);
      // Overflow: third word dropped
      wbuf[0] = 16'h1234; wbuf[1] = 16'h5678; wbuf[2] = 16'h9ABC;
      do_line(2, 3, 0, 0, 1, 0);
      // Collision of hsync rise and write
      wbuf[0] = 16'hC3C3; wbuf[1] = 16'h0F0F;
      do_line(2, 2, 1, 0, 1, 0);
      wbuf[0] = 16'hDEAD; wbuf[1] = 16'hBEEF;
      do_line(2, 2, 0, 0, 1, 0);
      // Underrun: three words needed, two written
      do_line(3, 0, 0, 0, 1, 0);
      // VSYNC during writes gives a blank following line
      wbuf[0] = 16'h1111; wbuf[1] = 16'h2222; wbuf[2] = 16'h3333;
      do_line(3, 3, 0, 1, 0, 0);
      wbuf[0] = 16'h4444; wbuf[1] = 16'h5555; wbuf[2] = 16'h6666;
      do_line(3, 3, 0, 0, 1, 0);
      // den drop mid-line
      do_line(3, 0, 0, 0, 1, 1);

      // Randomized lines
      for (int k = 0; k < 24; k++) begin
         int len;
         for (int j = 0; j < 8; j++) wbuf[j] = 16'($urandom);
         len = $urandom_range(5, 0);
         do_line(len, $urandom_range(len + 1, 0), ($urandom_range(3, 0) == 0),
                 ($urandom_range(7, 0) == 0), 1'b1, ($urandom_range(4, 0) == 0));
      end

      // Asynchronous reset in the middle of SHIFT
      wbuf[0] = 16'hFFFF; wbuf[1] = 16'hFFFF;
      do_line(2, 2, 0, 0, 0, 0);
      line_len_i = 9'd2;
      hsync_i    = 1'b1;
      swap_model();
      step();
      hsync_i = 1'b0;
      hde_i   = 1'b1;
      den_i   = 1'b1;
      repeat (10) step();
      check_val("pre-reset pixel_en", pixel_en_o, 1);
      check_val("pre-reset pixel", pixel_o, 1);
      reset_i = 1'b0;
      #1;
      check_val("async reset pixel", pixel_o, 0);
      check_val("async reset pixel_en", pixel_en_o, 0);
      check_val("async reset underrun", underrun_o, 0);
      step();
      reset_i = 1'b1;
      repeat (3) begin
         step();
         check_val("post reset pixel_en", pixel_en_o, 0);
         check_val("post reset underrun", underrun_o, 0);
      end
      hde_i = 1'b0;
      q_cur.delete();
      q_prev.delete();
      cur_blank  = 1'b0;
      prev_blank = 1'b0;
      step();
      wbuf[0] = 16'h0123; wbuf[1] = 16'h4567; wbuf[2] = 16'h89AB;
      do_line(3, 3, 0, 0, 1, 0);
      do_line(3, 0, 0, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
